// File: rtl/panel_bus_sequencer.sv
// panel_bus_sequencer: front-panel examine/deposit sequencer for the shared 6502
// address/data bus and external RAM. It waits for the CPU to halt and takes the
// bus break-before-make. It then runs one timed RAM cycle, hands the bus back,
// and pulses ack.
// Optional feature: define PANEL_TIMEOUT_EN to bound the halt wait by TIMEOUT_CYC
// cycles. On expiry the access ends with ack+err and the bus is never touched.
module panel_bus_sequencer #(
  parameter int TURN_CYC    = 3,
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic [7:0]  d_in,
  input  logic        cpu_stopped,
  input  logic        phi2_sync,
  output logic        busy,
  output logic        ack,
  output logic        err,
  output logic [7:0]  rdata,
  output logic        bus_drive_n,
  output logic        phys_bus_en_n,
  output logic [15:0] a_out,
  output logic [7:0]  d_out,
  output logic        d_oe,
  output logic        ram_cs_n,
  output logic        rw_out
);

  // Reject phase lengths the 8-bit saturating phase counter cannot time.
  if (TURN_CYC < 1 || TURN_CYC > 255 || SETUP_CYC < 1 || SETUP_CYC > 255 ||
      STROBE_CYC < 1 || STROBE_CYC > 255 || HOLD_CYC < 1 || HOLD_CYC > 255 ||
      TIMEOUT_CYC < 1) begin : g_bad_param
    $error("panel_bus_sequencer: phase lengths must be 1..255, timeout >= 1");
  end

  localparam logic [7:0] TURN_LAST   = 8'(TURN_CYC - 1);
  localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
  localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_HALT, S_RELEASE, S_SETUP, S_STROBE, S_HOLD, S_RETURN, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  phase_cnt;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        timeout_hit;
  logic        drive_n_nxt, phys_n_nxt, cs_n_nxt, rw_nxt, doe_nxt;

`ifdef PANEL_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Halt-wait timer: counts cycles spent in WAIT_HALT, cleared whenever we leave.
  always_ff @(posedge clk) begin
    if (!rst_n)                                            tmo_cnt <= '0;
    else if (state == S_WAIT_HALT && state_nxt == S_WAIT_HALT) tmo_cnt <= tmo_cnt + 1'b1;
    else                                                   tmo_cnt <= '0;
  end

  assign timeout_hit = (state == S_WAIT_HALT) && (tmo_cnt == TMO_LAST);

  // err qualifies the ack of an access that gave up waiting for the halt.
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else        err <= (state == S_WAIT_HALT) && (state_nxt == S_DONE);
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Phase timer: restarts on every state change, saturates so it never wraps.
  always_ff @(posedge clk) begin
    if (!rst_n)                  phase_cnt <= '0;
    else if (state_nxt != state) phase_cnt <= '0;
    else if (phase_cnt != 8'hFF) phase_cnt <= phase_cnt + 8'd1;
  end

  // Next state, and bus-control values for the state being entered.
  always_comb begin
    state_nxt   = state;
    drive_n_nxt = 1'b1;
    phys_n_nxt  = 1'b0;
    cs_n_nxt    = 1'b1;
    rw_nxt      = 1'b1;
    doe_nxt     = 1'b0;
    case (state)
      S_IDLE:      if (req) state_nxt = S_WAIT_HALT;
      S_WAIT_HALT: if (cpu_stopped && !phi2_sync) state_nxt = S_RELEASE;
                   else if (timeout_hit)          state_nxt = S_DONE;
      // CPU resumed before we drove anything: hand the bus straight back.
      S_RELEASE:   if (!cpu_stopped)                state_nxt = S_WAIT_HALT;
                   else if (phase_cnt == TURN_LAST) state_nxt = S_SETUP;
      S_SETUP:     if (phase_cnt == SETUP_LAST)  state_nxt = S_STROBE;
      S_STROBE:    if (phase_cnt == STROBE_LAST) state_nxt = S_HOLD;
      S_HOLD:      if (phase_cnt == HOLD_LAST)   state_nxt = S_RETURN;
      S_RETURN:    if (phase_cnt == TURN_LAST)   state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    // Transceivers and FPGA drivers are never enabled together.
    case (state_nxt)
      S_RELEASE, S_RETURN: phys_n_nxt = 1'b1;
      S_SETUP, S_STROBE, S_HOLD: begin
        phys_n_nxt  = 1'b1;
        drive_n_nxt = 1'b0;
        rw_nxt      = ~wr_q;
        doe_nxt     = wr_q;
        cs_n_nxt    = (state_nxt != S_STROBE);
      end
      default: ;
    endcase
  end

  // Registered outputs, request latch and read-data capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      ack           <= 1'b0;
      rdata         <= '0;
      bus_drive_n   <= 1'b1;
      phys_bus_en_n <= 1'b0;
      a_out         <= '0;
      d_out         <= '0;
      d_oe          <= 1'b0;
      ram_cs_n      <= 1'b1;
      rw_out        <= 1'b1;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
    end else begin
      busy          <= (state_nxt != S_IDLE);
      ack           <= (state_nxt == S_DONE);
      bus_drive_n   <= drive_n_nxt;
      phys_bus_en_n <= phys_n_nxt;
      d_oe          <= doe_nxt;
      ram_cs_n      <= cs_n_nxt;
      rw_out        <= rw_nxt;
      if (state == S_IDLE && req) begin
        wr_q    <= wr;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == S_RELEASE && state_nxt == S_SETUP) begin
        a_out <= addr_q;
        d_out <= wdata_q;
      end
      // RAM data is sampled at the end of the strobe, after its access time.
      if (state == S_STROBE && phase_cnt == STROBE_LAST && !wr_q)
        rdata <= d_in;
    end
  end

endmodule

// File: tb/tb_panel_bus_sequencer.sv
// Bench for panel_bus_sequencer: directed and randomized examine/deposit accesses.
// A RAM model answers the bus, a scoreboard holds the expected ack timing and data,
// and a negedge monitor checks bus rules every cycle.
module tb_panel_bus_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, req, wr, cpu_stopped, phi2_sync;
  logic [15:0] addr;
  logic [7:0]  wdata, d_in;
  logic        busy, ack, err, bus_drive_n, phys_bus_en_n, d_oe, ram_cs_n, rw_out;
  logic [7:0]  rdata, d_out;
  logic [15:0] a_out;

  always #20 clk = ~clk;

  panel_bus_sequencer #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
    .d_in(d_in), .cpu_stopped(cpu_stopped), .phi2_sync(phi2_sync),
    .busy(busy), .ack(ack), .err(err), .rdata(rdata),
    .bus_drive_n(bus_drive_n), .phys_bus_en_n(phys_bus_en_n),
    .a_out(a_out), .d_out(d_out), .d_oe(d_oe), .ram_cs_n(ram_cs_n), .rw_out(rw_out)
  );

`ifdef PANEL_TIMEOUT_EN
  localparam int HALT_DLY = 10;
`else
  localparam int HALT_DLY = 50;
`endif

  typedef struct {
    int         ack_cyc;
    bit         err;
    logic [7:0] rdata;
  } exp_t;

  int          ntests = 0, nfail = 0;
  int          cyc = 0;
  int          cs_len = 0, cs_pulses = 0, n_cs_exp = 0;
  bit          cs_abort = 1'b0;
  bit          cur_wr = 1'b0;
  logic [15:0] cur_addr = '0;
  logic [7:0]  cur_data = '0;
  logic [7:0]  last_rd = '0;
  logic [7:0]  mem [0:65535];
  exp_t        sb[$];
  exp_t        mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM: data appears only once chip select has been low for its full access time.
  assign d_in = (!ram_cs_n && rw_out && cs_len >= 4) ? mem[a_out] : 8'hEE;

  always @(posedge clk)
    if (!ram_cs_n && !rw_out) mem[a_out] = d_oe ? d_out : 8'h00;

  // Monitor: bus ownership rules, strobe width and scoreboard on ack.
  always @(negedge clk) begin
    chk("bus_owner_excl", 32'(bus_drive_n | phys_bus_en_n), 1);
    if (d_oe) chk("d_oe_qualified", 32'(!bus_drive_n && cur_wr), 1);
    if (!bus_drive_n) begin
      chk("a_out", a_out, cur_addr);
      chk("d_oe_in_drive", d_oe, cur_wr);
      chk("rw_out_in_drive", rw_out, !cur_wr);
      if (cur_wr) chk("d_out", d_out, cur_data);
    end
    if (!ram_cs_n) cs_len++;
    else if (cs_len != 0) begin
      if (!cs_abort) begin
        chk("cs_width", cs_len, 4);
        cs_pulses++;
      end
      cs_len   = 0;
      cs_abort = 1'b0;
    end
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        ntests++;
        nfail++;
        $display("FAIL ack_unexpected: got ack with nothing outstanding (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_cycle", cyc, mon_e.ack_cyc);
        chk("err", err, mon_e.err);
        chk("rdata", rdata, mon_e.rdata);
      end
    end
  end

  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (ack === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      ntests++;
      nfail++;
      $display("FAIL ack_timeout: got no ack within 400 cycles, expected ack");
    end
    @(negedge clk);
    chk("idle_after_done", busy, 0);
  endtask

  // One access; dly cycles of halt wait held either by cpu_stopped=0 or by phi2 high.
  task automatic issue(input bit w, input logic [15:0] a, input logic [7:0] dt,
                       input int dly, input bit use_phi);
    exp_t e;
    int   e0;
    @(negedge clk);
    cur_wr = w; cur_addr = a; cur_data = dt;
    req = 1'b1; wr = w; addr = a; wdata = dt;
    if (dly > 0 && use_phi) begin cpu_stopped = 1'b1; phi2_sync = 1'b1; end
    else if (dly > 0)       begin cpu_stopped = 1'b0; phi2_sync = 1'b0; end
    else                    begin cpu_stopped = 1'b1; phi2_sync = 1'b0; end
    @(negedge clk);
    e0  = cyc;
    req = 1'b0; wr = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
    if (!w) last_rd = mem[a];
    e.ack_cyc = e0 + dly + 14;
    e.err     = 1'b0;
    e.rdata   = last_rd;
    sb.push_back(e);
    n_cs_exp++;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("halt_wait_drive_n", bus_drive_n, 1);
      chk("halt_wait_phys_en_n", phys_bus_en_n, 0);
      chk("halt_wait_busy", busy, 1);
    end
    cpu_stopped = 1'b1;
    phi2_sync   = 1'b0;
    wait_ack();
    if (w) chk("ram_written", mem[a], dt);
  endtask

  initial begin
    exp_t e;
    int   e0;
    rst_n = 1'b0; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    cpu_stopped = 1'b1; phi2_sync = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h0200] = 8'hA5;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_drive_n", bus_drive_n, 1);
    chk("rst_phys_en_n", phys_bus_en_n, 0);
    chk("rst_cs_n", ram_cs_n, 1);
    chk("rst_rw", rw_out, 1);
    chk("rst_d_oe", d_oe, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_d_out", d_out, 0);
    rst_n = 1'b1;

    issue(1'b0, 16'h0200, 8'h00, 0, 1'b0);
    chk("read_a5", rdata, 8'hA5);
    issue(1'b1, 16'h1234, 8'h3C, 0, 1'b0);
    issue(1'b0, 16'h1234, 8'h00, 0, 1'b0);
    chk("readback_3c", rdata, 8'h3C);
    issue(1'b0, 16'h0210, 8'h00, HALT_DLY, 1'b0);
    issue(1'b1, 16'h0220, 8'h5A, 3, 1'b1);

    // Abort in RELEASE: CPU restarts right after the takeover begins.
    @(negedge clk);
    cur_wr = 1'b0; cur_addr = 16'h0300; cur_data = 8'h00;
    req = 1'b1; wr = 1'b0; addr = 16'h0300; cpu_stopped = 1'b1;
    @(negedge clk);
    e0 = cyc; req = 1'b0;
    @(negedge clk);
    chk("release_phys_en_n", phys_bus_en_n, 1);
    chk("release_drive_n", bus_drive_n, 1);
    cpu_stopped = 1'b0;
    @(negedge clk);
    chk("abort_phys_en_n", phys_bus_en_n, 0);
    chk("abort_busy", busy, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_cs", ram_cs_n, 1);
    end
    last_rd   = mem[16'h0300];
    e.ack_cyc = e0 + 21;
    e.err     = 1'b0;
    e.rdata   = last_rd;
    sb.push_back(e);
    n_cs_exp++;
    cpu_stopped = 1'b1;
    wait_ack();

    // Reset in the middle of the strobe.
    @(negedge clk);
    cur_wr = 1'b0; cur_addr = 16'h0400;
    req = 1'b1; wr = 1'b0; addr = 16'h0400;
    @(negedge clk);
    req = 1'b0;
    repeat (6) @(negedge clk);
    chk("strobe_cs_low", ram_cs_n, 0);
    cs_abort = 1'b1;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("midrst_cs_n", ram_cs_n, 1);
    chk("midrst_drive_n", bus_drive_n, 1);
    chk("midrst_phys_en_n", phys_bus_en_n, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ack", ack, 0);
    rst_n   = 1'b1;
    last_rd = 8'h00;

    for (int n = 0; n < 24; n++)
      issue(1'($urandom), 16'h1200 + 16'($urandom_range(0, 7)), 8'($urandom),
            int'($urandom_range(0, 6)), 1'($urandom));

`ifdef PANEL_TIMEOUT_EN
    // Halt never arrives: access gives up with err and leaves the bus alone.
    @(negedge clk);
    cur_wr = 1'b0; cur_addr = 16'h0500;
    req = 1'b1; wr = 1'b0; addr = 16'h0500; cpu_stopped = 1'b0;
    @(negedge clk);
    e0 = cyc; req = 1'b0;
    e.ack_cyc = e0 + 16;
    e.err     = 1'b1;
    e.rdata   = last_rd;
    sb.push_back(e);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("tmo_drive_n", bus_drive_n, 1);
      chk("tmo_phys_en_n", phys_bus_en_n, 0);
    end
    wait_ack();
    cpu_stopped = 1'b1;
`endif

    repeat (3) @(negedge clk);
    chk("cs_pulse_count", cs_pulses, n_cs_exp);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
